// File: rtl/dds_phase_gen.sv
// DDS phase generator: frequency-word accumulator with LUT-ready gating,
// deferred frequency updates on wrap, and registered SRAM addressing outputs.
module dds_phase_gen #(
  parameter int ACC_W = 32
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             writed,
  input  logic             start,
  input  logic             stop,
  input  logic             fw_valid,
  input  logic [ACC_W-1:0] fw_data,
  output logic             fw_ready,
  input  logic [14:0]      phase_off,
  output logic             cen,
  output logic             sign,
  output logic [13:0]      index,
  output logic             amp_valid,
  output logic             wrap
);

  typedef enum logic [1:0] {
    WAIT_LUT = 2'd0,
    IDLE     = 2'd1,
    RUN      = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [ACC_W-1:0] acc_r, fw_active_r, fw_pend_r;
  logic             pend_r;
  logic [ACC_W:0]   sum_s;
  logic             step_s, carry_s;
  logic [14:0]      phase_s;
  logic             cen_r, sign_r, amp_valid_r, wrap_r;
  logic [13:0]      index_r;

  // Next-state selection; a LUT reload overrides everything, stop beats start.
  always_comb begin
    state_nxt_s = state_r;
    if (!writed) begin
      state_nxt_s = WAIT_LUT;
    end else begin
      case (state_r)
        WAIT_LUT: state_nxt_s = IDLE;
        IDLE:     state_nxt_s = (start && !stop) ? RUN : IDLE;
        RUN:      state_nxt_s = stop ? IDLE : RUN;
        default:  state_nxt_s = WAIT_LUT;
      endcase
    end
  end

  // Accumulation only happens while RUN persists; leaving RUN clears acc instead.
  always_comb begin
    sum_s   = {1'b0, acc_r} + {1'b0, fw_active_r};
    step_s  = (state_r == RUN) && (state_nxt_s == RUN);
    carry_s = step_s && sum_s[ACC_W];
    phase_s = acc_r[ACC_W-1 -: 15] + phase_off;
  end

  // State and phase accumulator.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_r <= WAIT_LUT;
      acc_r   <= {ACC_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (step_s) begin
        acc_r <= sum_s[ACC_W-1:0];
      end else begin
        acc_r <= {ACC_W{1'b0}};
      end
    end
  end

  // Frequency-word handshake; in RUN the new word lands together with the wrap.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      fw_active_r <= {ACC_W{1'b0}};
      fw_pend_r   <= {ACC_W{1'b0}};
      pend_r      <= 1'b0;
    end else if (pend_r) begin
      if ((state_r != RUN) || carry_s) begin
        fw_active_r <= fw_pend_r;
        pend_r      <= 1'b0;
      end else begin
        pend_r      <= 1'b1;
      end
    end else if (fw_valid) begin
      fw_pend_r <= fw_data;
      pend_r    <= 1'b1;
    end else begin
      pend_r    <= 1'b0;
    end
  end

  // Registered SRAM-side outputs, one cycle behind the accumulator.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      cen_r       <= 1'b1;
      amp_valid_r <= 1'b0;
      sign_r      <= 1'b0;
      index_r     <= 14'd0;
      wrap_r      <= 1'b0;
    end else begin
      cen_r       <= (state_nxt_s != RUN);
      amp_valid_r <= ~cen_r;
      sign_r      <= phase_s[14];
      index_r     <= phase_s[13:0];
      wrap_r      <= carry_s;
    end
  end

  assign fw_ready  = ~pend_r;
  assign cen       = cen_r;
  assign amp_valid = amp_valid_r;
  assign sign      = sign_r;
  assign index     = index_r;
  assign wrap      = wrap_r;

endmodule

// File: doc/dds_phase_gen.md
DDS_PHASE_GEN -- requirements
Module: dds_phase_gen

Interface
REQ-001 Parameter ACC_W, default 32, SHALL set the phase accumulator width; legal range is 16..48.
REQ-002 sys_clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 writed  in  1  SHALL be the LUT-loaded flag from the sine-amplitude block; 1 means SRAM reads are valid.
REQ-005 start  in  1  SHALL be the run request, level-sampled.
REQ-006 stop  in  1  SHALL be the halt request, level-sampled; it SHALL take priority over start.
REQ-007 fw_valid  in  1  SHALL flag a new frequency word on fw_data.
REQ-008 fw_data  in  ACC_W  SHALL be the frequency (phase increment) word.
REQ-009 fw_ready  out  1  SHALL be high when no frequency word is pending.
REQ-010 phase_off  in  15  SHALL be the static phase offset, added to acc[ACC_W-1:ACC_W-15].
REQ-011 cen  out  1  SHALL be the SRAM chip enable, active-low.
REQ-012 sign  out  1  SHALL be the half-wave select: 0 = positive half, 1 = negated half.
REQ-013 index  out  14  SHALL be the SRAM read address.
REQ-014 amp_valid  out  1  SHALL flag that sin_amp from the sine-amplitude block corresponds to the address issued one cycle earlier.
REQ-015 wrap  out  1  SHALL pulse for one cycle when the accumulator carries out of bit ACC_W-1.

Function
REQ-016 The state machine SHALL have exactly three states: WAIT_LUT, IDLE, RUN.
REQ-017 WAIT_LUT SHALL hold acc = 0 and cen = 1, and SHALL move to IDLE on the first cycle writed = 1 is sampled.
REQ-018 IDLE SHALL hold acc = 0 and cen = 1, and SHALL move to RUN when start = 1 and stop = 0.
REQ-019 RUN SHALL perform acc <= acc + fw_active each cycle, modulo 2^ACC_W, and SHALL drive cen = 0.
REQ-020 In RUN, stop = 1 SHALL move the block to IDLE, clear acc, and drive cen = 1 from the next cycle.
REQ-021 In any state, writed = 0 (LUT reload) SHALL force WAIT_LUT, clear acc, and drive cen = 1 from the next cycle.
REQ-022 The output phase p SHALL be acc[ACC_W-1:ACC_W-15] + phase_off, computed modulo 2^15.
REQ-023 Outputs SHALL be registered: sign = p[14] and index = p[13:0]; outputs SHALL lag acc by one cycle.
REQ-024 amp_valid SHALL equal cen = 0 delayed by one cycle, and SHALL be 0 in any cycle following cen = 1.
REQ-025 Handshake: a frequency word SHALL be accepted when fw_valid = 1 and fw_ready = 1; it is stored as pending and fw_ready drops to 0.
REQ-026 In WAIT_LUT or IDLE, a pending word SHALL become fw_active on the next cycle, and fw_ready SHALL return to 1.
REQ-027 In RUN, a pending word SHALL become fw_active only in the cycle wrap is asserted; the addition producing that wrap SHALL use the old fw_active.
REQ-028 fw_valid with fw_ready = 0 SHALL be ignored; the pending word SHALL NOT be overwritten.
REQ-029 A pending word and fw_active SHALL be retained across WAIT_LUT, IDLE and stop transitions.
REQ-030 With fw_active = 0 in RUN, the phase SHALL hold constant and wrap SHALL never assert.

Reset
REQ-031 While reset = 0 the block SHALL hold: state WAIT_LUT, acc = 0, fw_active = 0, pending empty, fw_ready = 1, cen = 1, sign = 0, index = 0, amp_valid = 0, wrap = 0.
REQ-032 Assertion of reset mid-RUN SHALL apply all REQ-031 values immediately, without waiting for a clock edge.

Verification
REQ-033 Startup: writed = 0 for 20 cycles with start = 1 -> cen stays 1, amp_valid stays 0; after writed = 1, IDLE, then RUN one cycle later.
REQ-034 Sweep: ACC_W = 32, fw = 0x0002_0000 accepted in IDLE, phase_off = 0, then start -> index steps 0,1,2,...,0x3FFF with sign = 0, then 0..0x3FFF with sign = 1; wrap pulses once per 32768 cycles.
REQ-035 Offset: fw = 0 and phase_off = 0x4001 in RUN -> sign = 1 and index = 0x0001 constant; wrap never asserts.
REQ-036 Deferred update: in RUN with fw = 0x8000_0000, send fw = 0x4000_0000 -> fw_ready = 0 until the next wrap; the new step applies after that wrap; a second fw_valid while pending is ignored.
REQ-037 Reload/stop: drop writed mid-RUN -> cen = 1 next cycle, amp_valid = 0 one cycle later, state WAIT_LUT; assert stop and start together in IDLE -> remains IDLE.
REQ-038 Async reset: pulse reset low between clock edges mid-RUN -> all outputs take REQ-031 values before the next edge.
